// File: rtl/fsm_seq_ctrl.sv
// Parametrised sequence controller: walks STAGES states, advancing when input A
// matches a per-stage pattern bit, with dwell timeout, clear, hold and a completion count.
module fsm_seq_ctrl #(
  parameter int STAGES  = 4,
  parameter     PATTERN = 4'b0101,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 8,
  localparam int SW     = (STAGES > 2) ? $clog2(STAGES) : 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             En,
  input  logic             Clr,
  input  logic             A,
  output logic [SW-1:0]    state,
  output logic             busy,
  output logic             K2,
  output logic             K1,
  output logic             Tout,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int DW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [STAGES-1:0] PAT      = PATTERN;
  localparam logic [SW-1:0]     LAST_ST  = SW'(STAGES - 1);
  localparam logic [SW-1:0]     PEN_ST   = SW'(STAGES - 2);
  localparam logic [DW-1:0]     DW_MAX   = DW'(TIMEOUT);
  localparam logic [DW-1:0]     TO_FIRE  = (TIMEOUT > 0) ? DW'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  if (STAGES < 2) begin : g_bad_stages
    $error("fsm_seq_ctrl: STAGES must be at least 2 (got %0d)", STAGES);
  end
  if ($bits(PATTERN) != STAGES) begin : g_bad_pattern
    $error("fsm_seq_ctrl: PATTERN width %0d differs from STAGES %0d", $bits(PATTERN), STAGES);
  end

  logic [DW-1:0]    dwell, dwell_nxt;
  logic [SW-1:0]    state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             k1_nxt, k2_nxt, tout_nxt;
  logic             match, at_last;

  assign busy    = (state != '0);
  assign match   = (A == PAT[state]);
  assign at_last = (state == LAST_ST);

  // Priority per edge: clear, hold, advance, timeout, then dwell count.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_nxt = state;
    dwell_nxt = dwell;
    cnt_nxt   = done_cnt;
    k1_nxt    = 1'b0;
    k2_nxt    = 1'b0;
    tout_nxt  = 1'b0;

    if (Clr) begin
      state_nxt = '0;
      dwell_nxt = '0;
    end else if (!En) begin
      // hold state and dwell; strobes stay at their default of 0
    end else if (match) begin
      state_nxt = at_last ? '0 : state + 1'b1;
      dwell_nxt = '0;
      k2_nxt    = (state == PEN_ST);
      k1_nxt    = at_last;
      if (at_last && done_cnt != CNT_MAX) cnt_nxt = done_cnt + 1'b1;
    end else if (TIMEOUT > 0 && state != '0 && dwell == TO_FIRE) begin
      state_nxt = '0;
      dwell_nxt = '0;
      tout_nxt  = 1'b1;
    end else if (state != '0 && dwell != DW_MAX) begin
      dwell_nxt = dwell + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= '0;
      dwell    <= '0;
      done_cnt <= '0;
      K1       <= 1'b0;
      K2       <= 1'b0;
      Tout     <= 1'b0;
    end else begin
      state    <= state_nxt;
      dwell    <= dwell_nxt;
      done_cnt <= cnt_nxt;
      K1       <= k1_nxt;
      K2       <= k2_nxt;
      Tout     <= tout_nxt;
    end
  end

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Directed bench for fsm_seq_ctrl: default instance plus a narrow-counter
// instance and a two-stage instance, each compared against hand-computed values.
module tb_fsm_seq_ctrl;

  logic Clock = 1'b0;
  logic Reset, En, Clr;
  logic a0, a1, a2;

  logic [1:0] st0;  logic busy0, k2_0, k1_0, tout0;  logic [7:0] cnt0;
  logic [1:0] st1;  logic busy1, k2_1, k1_1, tout1;  logic [1:0] cnt1;
  logic [0:0] st2;  logic busy2, k2_2, k1_2, tout2;  logic [7:0] cnt2;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  fsm_seq_ctrl dut0 (
    .Clock(Clock), .Reset(Reset), .En(En), .Clr(Clr), .A(a0),
    .state(st0), .busy(busy0), .K2(k2_0), .K1(k1_0), .Tout(tout0), .done_cnt(cnt0)
  );

  fsm_seq_ctrl #(.CNT_W(2)) dut1 (
    .Clock(Clock), .Reset(Reset), .En(En), .Clr(Clr), .A(a1),
    .state(st1), .busy(busy1), .K2(k2_1), .K1(k1_1), .Tout(tout1), .done_cnt(cnt1)
  );

  fsm_seq_ctrl #(.STAGES(2), .PATTERN(2'b01)) dut2 (
    .Clock(Clock), .Reset(Reset), .En(En), .Clr(Clr), .A(a2),
    .state(st2), .busy(busy2), .K2(k2_2), .K1(k1_2), .Tout(tout2), .done_cnt(cnt2)
  );

  // Observation vectors: {state, busy, K2, K1, Tout, done_cnt}
  function automatic logic [13:0] obs0();
    return {st0, busy0, k2_0, k1_0, tout0, cnt0};
  endfunction
  function automatic logic [13:0] exp0(int st, bit k2, bit k1, bit to, int cnt);
    return {2'(st), st != 0, k2, k1, to, 8'(cnt)};
  endfunction
  function automatic logic [7:0] obs1();
    return {st1, busy1, k2_1, k1_1, tout1, cnt1};
  endfunction
  function automatic logic [7:0] exp1(int st, bit k2, bit k1, bit to, int cnt);
    return {2'(st), st != 0, k2, k1, to, 2'(cnt)};
  endfunction
  function automatic logic [12:0] obs2();
    return {st2, busy2, k2_2, k1_2, tout2, cnt2};
  endfunction
  function automatic logic [12:0] exp2(int st, bit k2, bit k1, bit to, int cnt);
    return {1'(st), st != 0, k2, k1, to, 8'(cnt)};
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    logic [13:0] e;
    Reset = 1'b0; En = 1'b0; Clr = 1'b0; a0 = 1'b0; a1 = 1'b0; a2 = 1'b0;
    #2;
    e = exp0(0, 0, 0, 0, 0);
    checks++;
    if (obs0() !== e) begin errors++; $display("FAIL reset_dut0: got %b exp %b", obs0(), e); end
    checks++;
    if (obs1() !== exp1(0, 0, 0, 0, 0)) begin errors++; $display("FAIL reset_dut1: got %b exp %b", obs1(), exp1(0, 0, 0, 0, 0)); end
    checks++;
    if (obs2() !== exp2(0, 0, 0, 0, 0)) begin errors++; $display("FAIL reset_dut2: got %b exp %b", obs2(), exp2(0, 0, 0, 0, 0)); end
    @(negedge Clock);
    Reset = 1'b1;
    En    = 1'b1;
  endtask

  task automatic test_sequence();
    logic [13:0] e;
    bit a_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [13:0] exp_seq [4];
    exp_seq[0] = exp0(1, 0, 0, 0, 0);
    exp_seq[1] = exp0(2, 0, 0, 0, 0);
    exp_seq[2] = exp0(3, 1, 0, 0, 0);
    exp_seq[3] = exp0(0, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      a0 = a_seq[i];
      step();
      checks++;
      if (obs0() !== exp_seq[i]) begin errors++; $display("FAIL seq_step%0d: got %b exp %b", i, obs0(), exp_seq[i]); end
    end
    a0 = 1'b0;
    step();
    e = exp0(0, 0, 0, 0, 1);
    checks++;
    if (obs0() !== e) begin errors++; $display("FAIL seq_idle_after: got %b exp %b", obs0(), e); end
  endtask

  task automatic test_timeout();
    logic [13:0] e;
    a0 = 1'b1; step();
    a0 = 1'b0; step();
    // stage 2 advances on A=1, so A=0 is a non-match
    for (int i = 1; i <= 7; i++) begin
      step();
      e = exp0(2, 0, 0, 0, 1);
      checks++;
      if (obs0() !== e) begin errors++; $display("FAIL timeout_dwell%0d: got %b exp %b", i, obs0(), e); end
    end
    step();
    e = exp0(0, 0, 0, 1, 1);
    checks++;
    if (obs0() !== e) begin errors++; $display("FAIL timeout_fire: got %b exp %b", obs0(), e); end
    step();
    e = exp0(0, 0, 0, 0, 1);
    checks++;
    if (obs0() !== e) begin errors++; $display("FAIL timeout_strobe_clear: got %b exp %b", obs0(), e); end

    a0 = 1'b1; step();
    a0 = 1'b0; step();
    repeat (7) step();
    a0 = 1'b1; step();
    e = exp0(3, 1, 0, 0, 1);
    checks++;
    if (obs0() !== e) begin errors++; $display("FAIL timeout_7_then_adv: got %b exp %b", obs0(), e); end
    a0 = 1'b0; step();
    e = exp0(0, 0, 1, 0, 2);
    checks++;
    if (obs0() !== e) begin errors++; $display("FAIL timeout_complete: got %b exp %b", obs0(), e); end
  endtask

  task automatic test_advance_beats_timeout();
    logic [13:0] e;
    a0 = 1'b1; step();
    repeat (7) step();
    e = exp0(1, 0, 0, 0, 2);
    checks++;
    if (obs0() !== e) begin errors++; $display("FAIL beat_dwell7: got %b exp %b", obs0(), e); end
    a0 = 1'b0; step();
    e = exp0(2, 0, 0, 0, 2);
    checks++;
    if (obs0() !== e) begin errors++; $display("FAIL beat_advance: got %b exp %b", obs0(), e); end
  endtask

  task automatic test_en_hold();
    logic [13:0] e;
    int bad = 0;
    En = 1'b0;
    for (int i = 0; i < 20; i++) begin
      a0 = i[0];
      step();
      if (obs0() !== exp0(2, 0, 0, 0, 2)) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL en_hold: got %0d bad cycles exp 0 (last %b)", bad, obs0()); end
    En = 1'b1; a0 = 1'b1; step();
    e = exp0(3, 1, 0, 0, 2);
    checks++;
    if (obs0() !== e) begin errors++; $display("FAIL en_resume: got %b exp %b", obs0(), e); end
  endtask

  task automatic test_clear_and_async_reset();
    logic [13:0] e;
    En = 1'b0; Clr = 1'b1; a0 = 1'b0; step();
    e = exp0(0, 0, 0, 0, 2);
    checks++;
    if (obs0() !== e) begin errors++; $display("FAIL clr_over_en: got %b exp %b", obs0(), e); end
    Clr = 1'b0; En = 1'b1;
    a0 = 1'b1; step();
    a0 = 1'b0; step();
    e = exp0(2, 0, 0, 0, 2);
    checks++;
    if (obs0() !== e) begin errors++; $display("FAIL pre_async: got %b exp %b", obs0(), e); end
    #2 Reset = 1'b0;
    #1;
    e = exp0(0, 0, 0, 0, 0);
    checks++;
    if (obs0() !== e) begin errors++; $display("FAIL async_reset: got %b exp %b", obs0(), e); end
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic test_saturation();
    logic [7:0] e;
    int exp_cnt [5] = '{1, 2, 3, 3, 3};
    for (int s = 0; s < 5; s++) begin
      a1 = 1'b1; step();
      a1 = 1'b0; step();
      a1 = 1'b1; step();
      a1 = 1'b0; step();
      e = exp1(0, 0, 1, 0, exp_cnt[s]);
      checks++;
      if (obs1() !== e) begin errors++; $display("FAIL sat_seq%0d: got %b exp %b", s, obs1(), e); end
    end
  endtask

  task automatic test_two_stages();
    logic [12:0] e;
    a2 = 1'b1; step();
    e = exp2(1, 1, 0, 0, 0);
    checks++;
    if (obs2() !== e) begin errors++; $display("FAIL two_stage_k2: got %b exp %b", obs2(), e); end
    a2 = 1'b0; step();
    e = exp2(0, 0, 1, 0, 1);
    checks++;
    if (obs2() !== e) begin errors++; $display("FAIL two_stage_k1: got %b exp %b", obs2(), e); end
    step();
    e = exp2(0, 0, 0, 0, 1);
    checks++;
    if (obs2() !== e) begin errors++; $display("FAIL two_stage_idle: got %b exp %b", obs2(), e); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_timeout();
    test_advance_beats_timeout();
    test_en_hold();
    test_clear_and_async_reset();
    test_saturation();
    test_two_stages();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_seq_ctrl.md
Name: fsm_seq_ctrl

Overview:
Parametrised sequence-controller FSM that steps through STAGES states, one step per matching level of input A against a programmable per-stage pattern. It is the generalised successor of the team's fixed four-state Idle/Start/Stop/Clear controller. It adds per-stage dwell timeout, synchronous clear, enable/hold and a saturating completion counter. It sits between a sampled control input and downstream logic that consumes the K1/K2 strobes.

Parameters:
STAGES, 4, number of states (min 2); stage 0 is Idle.
PATTERN, 4'b0101, STAGES-bit vector; bit i is the A level that advances stage i (defaults reproduce the 1,0,1,0 sequence).
TIMEOUT, 8, max cycles spent in any stage other than 0 before forced return to Idle; 0 disables the timeout.
CNT_W, 8, width of done_cnt.

Ports:
Clock  in  1  system clock, rising edge.
Reset  in  1  asynchronous active-low reset.
En  in  1  1 = FSM may advance or time out; 0 = hold state, outputs strobe 0.
Clr  in  1  synchronous clear to Idle; takes priority over En.
A  in  1  sampled control input.
state  out  SW  current stage index, where SW = max(1, clog2(STAGES)).
busy  out  1  combinational, state != 0.
K2  out  1  one-cycle strobe on the advance from stage STAGES-2 to STAGES-1.
K1  out  1  one-cycle strobe on the advance from stage STAGES-1 to 0 (sequence complete).
Tout  out  1  one-cycle strobe on a timeout return to Idle.
done_cnt  out  CNT_W  count of completed sequences, saturating.

Behaviour:
- Reset (async, Reset=0): state=0, K1=K2=Tout=0, done_cnt=0, dwell counter=0. Takes effect immediately, including mid-sequence. The first evaluation happens on the first rising Clock after Reset deasserts.
- Per-edge priority: Clr, then !En, then advance, then timeout.
- Clr=1: state<=0, dwell<=0, strobes<=0. done_cnt is unchanged.
- En=0 (Clr=0): state and dwell hold; strobes<=0.
- Advance: fires when A==PATTERN[state]. state<=state+1, and from STAGES-1 it wraps to 0. dwell<=0.
- No match: state holds, dwell<=dwell+1. The dwell counter saturates at TIMEOUT and its width is clog2(TIMEOUT+1).
- Timeout: fires when TIMEOUT>0, state!=0, no match and dwell==TIMEOUT-1. Then state<=0, dwell<=0, Tout<=1.
  - A stage therefore times out on its TIMEOUT-th consecutive non-matching cycle.
  - Stage 0 never times out; its dwell stays 0.
- Advance and timeout conditions in the same cycle: advance wins, no Tout.
- Strobes are registered: K1/K2/Tout go high in the cycle the new state is visible and are low otherwise. At most one strobe is high per cycle.
- STAGES=2: K2 fires on the 0->1 advance and K1 on the 1->0 advance.
- done_cnt increments on every K1 event and saturates at 2^CNT_W-1 (no wrap). Clr and timeout do not change it.
- state is registered and changes only on a Clock edge or async reset. busy is derived from state.
- Invalid parameters cause a simulation error at elaboration: STAGES<2, or a PATTERN width other than STAGES.

Test Plan:
1. Reset, then A=1,0,1,0 on successive edges (defaults) -> state 1,2,3,0. K2=1 only in the cycle state becomes 3. K1=1 only in the cycle state returns to 0. done_cnt=1.
2. Enter stage 2, then hold A=0 for 8 edges -> Tout=1 on the 8th edge with state=0, K1=0, done_cnt unchanged. With 7 edges then A=1 -> advance to 3 and no Tout.
3. In stage 1 at dwell=7, drive A=0 (match) -> state=2 and Tout=0 (advance beats timeout).
4. En=0 for 20 cycles while in stage 2 with A toggling -> state stays 2, no strobes, no timeout. Then En=1 and A=1 -> state=3 and K2=1.
5. Clr=1 with En=0 in stage 3 -> state=0 next edge, strobes 0, done_cnt held. Async Reset pulse mid-sequence -> state=0 and done_cnt=0 immediately, before any Clock edge.
6. CNT_W=2: run 5 full sequences -> done_cnt = 1,2,3,3,3 and K1 still pulses each time. STAGES=2, PATTERN=2'b01 -> A=1,0 gives K2 then K1 on consecutive edges.
